// File: rtl/otter_pkg.sv
// otter_pkg: types and constants shared by the OTTER pipeline stages.
package otter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      FULL,
      DROP
   } if_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: OTTER fetch stage, req/ack imem port, valid/ready to decode.
// Optional IF_MISALIGN_CHECK_EN turns misaligned PCs into a flagged NOP.
module instr_fetch
   import otter_pkg::*;
(
   input  logic        clk,
   input  logic        IF_RST,
   input  logic [31:0] PC_COUNT,
   output logic        IF_PC_WE,
   input  logic        IF_FLUSH,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_RD,
   input  logic        IMEM_ACK,
   input  logic        IMEM_RVALID,
   input  logic [31:0] IMEM_RDATA,
   output logic [31:0] IR,
   output logic [31:0] IR_PC,
   output logic        IR_VALID,
   input  logic        IR_READY
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic        IF_MISALIGN
`endif
);

   if_state_t   state;
   if_state_t   state_n;
   logic        in_req;
   logic        misalign;
   logic        acked;
   logic        take_pc;
   logic        take_ir;

   assign in_req = (state == REQ);

`ifdef IF_MISALIGN_CHECK_EN
   logic mis_q;

   assign misalign    = in_req && (PC_COUNT[1:0] != 2'b00);
   assign IF_MISALIGN = mis_q;

   always_ff @(posedge clk) begin
      if (IF_RST) begin
         mis_q <= 1'b0;
      end else if (IF_FLUSH || (state == FULL && IR_READY)) begin
         mis_q <= 1'b0;
      end else if (misalign) begin
         mis_q <= 1'b1;
      end
   end
`else
   assign misalign = 1'b0;
`endif

   assign IMEM_RD   = in_req && !misalign;
   assign IMEM_ADDR = in_req ? PC_COUNT : 32'h0;
   assign acked     = IMEM_RD && IMEM_ACK;
   assign IR_VALID  = (state == FULL) && !IF_FLUSH;
   assign IF_PC_WE  = !IF_RST &&
                      (IF_FLUSH || (state == FULL && IR_READY));

   assign take_pc = in_req && !IF_FLUSH && (acked || misalign);
   assign take_ir = (state == WAIT) && IMEM_RVALID && !IF_FLUSH;

   // Flush wins over every other event; an accepted request still owes
   // a response, so it must be drained in DROP before refetching.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: state_n = REQ;
         REQ: begin
            if (IF_FLUSH) begin
               state_n = acked ? DROP : REQ;
            end else if (misalign) begin
               state_n = FULL;
            end else if (acked) begin
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (IF_FLUSH) begin
               state_n = IMEM_RVALID ? REQ : DROP;
            end else if (IMEM_RVALID) begin
               state_n = FULL;
            end
         end
         FULL: begin
            if (IF_FLUSH || IR_READY) begin
               state_n = REQ;
            end
         end
         DROP: begin
            if (IMEM_RVALID) begin
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (IF_RST) begin
         state <= IDLE;
         IR    <= NOP_INSTR;
         IR_PC <= 32'h0;
      end else begin
         state <= state_n;
         if (take_pc) begin
            IR_PC <= PC_COUNT;
         end
         if (take_ir) begin
            IR <= IMEM_RDATA;
         end else if (take_pc && misalign) begin
            IR <= NOP_INSTR;
         end
      end
   end

endmodule
